// File: rtl/issue_ctrl.sv
// issue_ctrl: single-entry issue stage between the instruction buffer and
// the ALU / LS reservation slots. Holds one decoded instruction until its
// registers are hazard-free and its unit class has a free slot, then issues
// it to the lowest-index free slot. Tracks slot occupancy and pending writes.
// Optional feature macro: ISSUE_BYPASS_EN -- completions sampled on an edge
// feed that same edge's issue decision.
module issue_ctrl #(
    parameter int ALU_SLOTS  = 2,
    parameter int LS_SLOTS   = 2,
    parameter int OPT_WID    = 7,
    parameter int FUNCT3_WID = 3,
    parameter int REG_WID    = 5,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ib_vacant_alu,
    output logic                  ib_vacant_ls,
    input  logic                  ib_valid,
    input  logic [OPT_WID-1:0]    ib_opt,
    input  logic [FUNCT3_WID-1:0] ib_funct,
    input  logic [REG_WID-1:0]    ib_rs1,
    input  logic [REG_WID-1:0]    ib_rs2,
    input  logic [REG_WID-1:0]    ib_rd,
    input  logic [XLEN-1:0]       ib_imm,
    output logic                  alu_valid,
    output logic                  ls_valid,
    output logic [1:0]            fu_slot,
    output logic [OPT_WID-1:0]    fu_opt,
    output logic [FUNCT3_WID-1:0] fu_funct,
    output logic [REG_WID-1:0]    fu_rs1,
    output logic [REG_WID-1:0]    fu_rs2,
    output logic [REG_WID-1:0]    fu_rd,
    output logic [XLEN-1:0]       fu_imm,
    input  logic                  alu_done,
    input  logic [1:0]            alu_done_slot,
    input  logic                  ls_done,
    input  logic [1:0]            ls_done_slot
);
    localparam int NUM_REGS = 1 << REG_WID;

    localparam logic [OPT_WID-1:0] OP_B = 7'b1100011;
    localparam logic [OPT_WID-1:0] OP_I = 7'b0010011;
    localparam logic [OPT_WID-1:0] OP_R = 7'b0110011;
    localparam logic [OPT_WID-1:0] OP_L = 7'b0000011;
    localparam logic [OPT_WID-1:0] OP_S = 7'b0100011;

    typedef enum logic {S_EMPTY, S_HOLD} state_t;
    state_t state, state_next;

    // Held instruction
    logic [OPT_WID-1:0]    h_opt;
    logic [FUNCT3_WID-1:0] h_funct;
    logic [REG_WID-1:0]    h_rs1, h_rs2, h_rd;
    logic [XLEN-1:0]       h_imm;

    // Occupancy, per-slot destination and pending-write tracking
    logic [ALU_SLOTS-1:0] alu_busy, alu_busy_clr, alu_busy_view, alu_busy_next, alu_grant;
    logic [LS_SLOTS-1:0]  ls_busy, ls_busy_clr, ls_busy_view, ls_busy_next, ls_grant;
    logic [REG_WID-1:0]   alu_rd [ALU_SLOTS];
    logic [REG_WID-1:0]   ls_rd  [LS_SLOTS];
    logic [NUM_REGS-1:0]  pending, pending_clr, pending_view, pending_next;

    logic       is_alu, is_ls, reads_rs2, writes_rd, hazard;
    logic       alu_free, ls_free, issue_alu, issue_ls;
    logic [1:0] alu_pick, ls_pick;

    // Decode the held opcode into unit class and register usage.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_alu    = 1'b0;
        is_ls     = 1'b0;
        reads_rs2 = 1'b0;
        writes_rd = 1'b0;
        case (h_opt)
            OP_R: begin is_alu = 1'b1; reads_rs2 = 1'b1; writes_rd = 1'b1; end
            OP_I: begin is_alu = 1'b1; writes_rd = 1'b1; end
            OP_B: begin is_alu = 1'b1; reads_rs2 = 1'b1; end
            OP_L: begin is_ls  = 1'b1; writes_rd = 1'b1; end
            OP_S: begin is_ls  = 1'b1; reads_rs2 = 1'b1; end
            default: ;
        endcase
    end

    // Apply completion pulses; a done on a free or nonexistent slot changes nothing.
    always_comb begin
        alu_busy_clr = alu_busy;
        ls_busy_clr  = ls_busy;
        pending_clr  = pending;
        for (int i = 0; i < ALU_SLOTS; i++) begin
            if (alu_done && alu_done_slot == 2'(i) && alu_busy[i]) begin
                alu_busy_clr[i]        = 1'b0;
                pending_clr[alu_rd[i]] = 1'b0;
            end
        end
        for (int i = 0; i < LS_SLOTS; i++) begin
            if (ls_done && ls_done_slot == 2'(i) && ls_busy[i]) begin
                ls_busy_clr[i]        = 1'b0;
                pending_clr[ls_rd[i]] = 1'b0;
            end
        end
    end

`ifdef ISSUE_BYPASS_EN
    assign alu_busy_view = alu_busy_clr;
    assign ls_busy_view  = ls_busy_clr;
    assign pending_view  = pending_clr;
`else
    assign alu_busy_view = alu_busy;
    assign ls_busy_view  = ls_busy;
    assign pending_view  = pending;
`endif

    // Find the lowest-index free slot in each class (descending scan, last hit wins).
    always_comb begin
        alu_free  = 1'b0;
        alu_pick  = '0;
        alu_grant = '0;
        ls_free   = 1'b0;
        ls_pick   = '0;
        ls_grant  = '0;
        for (int i = ALU_SLOTS - 1; i >= 0; i--) begin
            if (!alu_busy_view[i]) begin
                alu_free     = 1'b1;
                alu_pick     = 2'(i);
                alu_grant    = '0;
                alu_grant[i] = 1'b1;
            end
        end
        for (int i = LS_SLOTS - 1; i >= 0; i--) begin
            if (!ls_busy_view[i]) begin
                ls_free     = 1'b1;
                ls_pick     = 2'(i);
                ls_grant    = '0;
                ls_grant[i] = 1'b1;
            end
        end
    end

    // x0 is never pending, so it cannot stall anything.
    assign hazard = (h_rs1 != '0 && pending_view[h_rs1])
                 || (reads_rs2 && h_rs2 != '0 && pending_view[h_rs2])
                 || (writes_rd && h_rd  != '0 && pending_view[h_rd]);

    // Next-state and issue decision; unknown opcodes are dropped without issue.
    always_comb begin
        state_next = state;
        issue_alu  = 1'b0;
        issue_ls   = 1'b0;
        case (state)
            S_EMPTY: if (ib_valid) state_next = S_HOLD;
            S_HOLD: begin
                if (!is_alu && !is_ls) begin
                    state_next = S_EMPTY;
                end else if (!hazard && ((is_alu && alu_free) || (is_ls && ls_free))) begin
                    issue_alu  = is_alu;
                    issue_ls   = is_ls;
                    state_next = S_EMPTY;
                end
            end
        endcase
    end

    // Occupancy and pending after this edge; a new writer's set beats a same-edge clear.
    always_comb begin
        alu_busy_next = alu_busy_clr | (issue_alu ? alu_grant : '0);
        ls_busy_next  = ls_busy_clr  | (issue_ls  ? ls_grant  : '0);
        pending_next  = pending_clr;
        if ((issue_alu || issue_ls) && writes_rd) pending_next[h_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_EMPTY;
        else        state <= state_next;
    end

    // Capture the instruction into the hold register when accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_opt <= '0; h_funct <= '0; h_rs1 <= '0; h_rs2 <= '0; h_rd <= '0; h_imm <= '0;
        end else if (state == S_EMPTY && ib_valid) begin
            h_opt <= ib_opt; h_funct <= ib_funct; h_rs1 <= ib_rs1;
            h_rs2 <= ib_rs2; h_rd <= ib_rd; h_imm <= ib_imm;
        end
    end

    // Record each issued slot's destination register for clearing on completion.
    // NOTE: no reset here; a slot's rd is only ever read while its busy bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ALU_SLOTS; i++)
            if (issue_alu && alu_grant[i]) alu_rd[i] <= writes_rd ? h_rd : '0;
        for (int i = 0; i < LS_SLOTS; i++)
            if (issue_ls && ls_grant[i]) ls_rd[i] <= writes_rd ? h_rd : '0;
    end

    // Tracking state and registered outputs (issue pulse, issued fields, vacancy).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_busy      <= '0;
            ls_busy       <= '0;
            pending       <= '0;
            ib_vacant_alu <= 1'b1;
            ib_vacant_ls  <= 1'b1;
            alu_valid     <= 1'b0;
            ls_valid      <= 1'b0;
            fu_slot       <= '0;
            fu_opt <= '0; fu_funct <= '0; fu_rs1 <= '0; fu_rs2 <= '0; fu_rd <= '0; fu_imm <= '0;
        end else begin
            alu_busy      <= alu_busy_next;
            ls_busy       <= ls_busy_next;
            pending       <= pending_next;
            ib_vacant_alu <= (state_next == S_EMPTY) && !(&alu_busy_next);
            ib_vacant_ls  <= (state_next == S_EMPTY) && !(&ls_busy_next);
            alu_valid     <= issue_alu;
            ls_valid      <= issue_ls;
            if (issue_alu || issue_ls) begin
                fu_slot  <= issue_alu ? alu_pick : ls_pick;
                fu_opt   <= h_opt;
                fu_funct <= h_funct;
                fu_rs1   <= h_rs1;
                fu_rs2   <= h_rs2;
                fu_rd    <= h_rd;
                fu_imm   <= h_imm;
            end
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed scenarios followed by a randomized run,
// every cycle compared against a behavioural model of slots and pending writes.
module tb_issue_ctrl;
    localparam int ALU_SLOTS = 2;
    localparam int LS_SLOTS  = 2;

    localparam logic [6:0] OPC_B   = 7'b1100011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_L   = 7'b0000011;
    localparam logic [6:0] OPC_S   = 7'b0100011;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ib_vacant_alu, ib_vacant_ls;
    logic        ib_valid = 1'b0;
    logic [6:0]  ib_opt = '0;
    logic [2:0]  ib_funct = '0;
    logic [4:0]  ib_rs1 = '0, ib_rs2 = '0, ib_rd = '0;
    logic [31:0] ib_imm = '0;
    logic        alu_valid, ls_valid;
    logic [1:0]  fu_slot;
    logic [6:0]  fu_opt;
    logic [2:0]  fu_funct;
    logic [4:0]  fu_rs1, fu_rs2, fu_rd;
    logic [31:0] fu_imm;
    logic        alu_done = 1'b0;
    logic [1:0]  alu_done_slot = '0;
    logic        ls_done = 1'b0;
    logic [1:0]  ls_done_slot = '0;

    int checks = 0;
    int errors = 0;

    issue_ctrl #(.ALU_SLOTS(ALU_SLOTS), .LS_SLOTS(LS_SLOTS)) dut (
        .clk(clk), .rst_n(rst_n),
        .ib_vacant_alu(ib_vacant_alu), .ib_vacant_ls(ib_vacant_ls),
        .ib_valid(ib_valid), .ib_opt(ib_opt), .ib_funct(ib_funct),
        .ib_rs1(ib_rs1), .ib_rs2(ib_rs2), .ib_rd(ib_rd), .ib_imm(ib_imm),
        .alu_valid(alu_valid), .ls_valid(ls_valid), .fu_slot(fu_slot),
        .fu_opt(fu_opt), .fu_funct(fu_funct), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2),
        .fu_rd(fu_rd), .fu_imm(fu_imm),
        .alu_done(alu_done), .alu_done_slot(alu_done_slot),
        .ls_done(ls_done), .ls_done_slot(ls_done_slot)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [6:0]  opt;
        logic [2:0]  funct;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } ins_t;

    bit   m_hold;
    ins_t m_ins;
    int   alu_owner [4];   // -1 = free, otherwise the register the occupant writes (0 = none)
    int   ls_owner  [4];
    bit   m_pend    [32];
    bit   e_alu_valid, e_ls_valid, e_vac_alu, e_vac_ls;
    int   e_slot;
    ins_t e_fu;

    function automatic void classify(input logic [6:0] opt, output bit known, output bit to_ls,
                                     output bit rd2, output bit wr);
        known = 1; to_ls = 0; rd2 = 0; wr = 0;
        case (opt)
            OPC_R: begin rd2 = 1; wr = 1; end
            OPC_I: wr = 1;
            OPC_B: rd2 = 1;
            OPC_L: begin to_ls = 1; wr = 1; end
            OPC_S: begin to_ls = 1; rd2 = 1; end
            default: known = 0;
        endcase
    endfunction

    task automatic model_reset();
        m_hold = 0;
        m_ins  = '0;
        for (int i = 0; i < 4; i++) begin alu_owner[i] = -1; ls_owner[i] = -1; end
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
        e_alu_valid = 0; e_ls_valid = 0; e_vac_alu = 1; e_vac_ls = 1;
        e_slot = 0; e_fu = '0;
    endtask

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic model_step();
        int  alu_view [4];
        int  ls_view  [4];
        bit  pend_view [32];
        bit  known, to_ls, rd2, wr, blocked;
        int  slot, nslots;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_alu_valid = 0;
        e_ls_valid  = 0;
        alu_view  = alu_owner;
        ls_view   = ls_owner;
        pend_view = m_pend;
        if (alu_done && int'(alu_done_slot) < ALU_SLOTS && alu_owner[alu_done_slot] >= 0) begin
            m_pend[alu_owner[alu_done_slot]] = 0;
            alu_owner[alu_done_slot] = -1;
        end
        if (ls_done && int'(ls_done_slot) < LS_SLOTS && ls_owner[ls_done_slot] >= 0) begin
            m_pend[ls_owner[ls_done_slot]] = 0;
            ls_owner[ls_done_slot] = -1;
        end
`ifdef ISSUE_BYPASS_EN
        alu_view  = alu_owner;
        ls_view   = ls_owner;
        pend_view = m_pend;
`endif
        if (m_hold) begin
            classify(m_ins.opt, known, to_ls, rd2, wr);
            if (!known) begin
                m_hold = 0;
            end else begin
                blocked = (m_ins.rs1 != 0 && pend_view[m_ins.rs1])
                       || (rd2 && m_ins.rs2 != 0 && pend_view[m_ins.rs2])
                       || (wr && m_ins.rd != 0 && pend_view[m_ins.rd]);
                nslots = to_ls ? LS_SLOTS : ALU_SLOTS;
                slot = -1;
                for (int i = nslots - 1; i >= 0; i--)
                    if ((to_ls ? ls_view[i] : alu_view[i]) < 0) slot = i;
                if (!blocked && slot >= 0) begin
                    if (to_ls) begin ls_owner[slot]  = wr ? int'(m_ins.rd) : 0; e_ls_valid  = 1; end
                    else       begin alu_owner[slot] = wr ? int'(m_ins.rd) : 0; e_alu_valid = 1; end
                    if (wr && m_ins.rd != 0) m_pend[m_ins.rd] = 1;
                    e_slot = slot;
                    e_fu   = m_ins;
                    m_hold = 0;
                end
            end
        end else if (ib_valid) begin
            m_hold = 1;
            m_ins  = {ib_opt, ib_funct, ib_rs1, ib_rs2, ib_rd, ib_imm};
        end
        e_vac_alu = 0;
        e_vac_ls  = 0;
        for (int i = 0; i < ALU_SLOTS; i++) if (alu_owner[i] < 0) e_vac_alu = !m_hold;
        for (int i = 0; i < LS_SLOTS; i++)  if (ls_owner[i]  < 0) e_vac_ls  = !m_hold;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic compare_all();
        check("vacant_alu", 64'(ib_vacant_alu), 64'(e_vac_alu));
        check("vacant_ls",  64'(ib_vacant_ls),  64'(e_vac_ls));
        check("alu_valid",  64'(alu_valid),     64'(e_alu_valid));
        check("ls_valid",   64'(ls_valid),      64'(e_ls_valid));
        check("fu_slot",    64'(fu_slot),       64'(e_slot));
        check("fu_fields",  64'({fu_opt, fu_funct, fu_rs1, fu_rs2, fu_rd, fu_imm}), 64'(e_fu));
    endtask

    // One clock: edge, model update, full comparison, then drop one-cycle pulses.
    task automatic cycle();
        if (ib_valid && m_hold) begin
            $display("FAIL ib_valid_not_empty: observed ib_valid=1 expected 0 while holding");
            $fatal(1, "ib_valid driven while an instruction is held");
        end
        @(posedge clk);
        #1;
        model_step();
        compare_all();
        ib_valid = 1'b0;
        alu_done = 1'b0;
        ls_done  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic send(input logic [6:0] opt, input int rs1, input int rs2, input int rd);
        ib_valid = 1'b1;
        ib_opt   = opt;
        ib_funct = 3'($urandom_range(0, 7));
        ib_rs1   = 5'(rs1);
        ib_rs2   = 5'(rs2);
        ib_rd    = 5'(rd);
        ib_imm   = $urandom;
    endtask

    task automatic done_alu(input int slot);
        alu_done = 1'b1; alu_done_slot = 2'(slot);
    endtask

    task automatic done_ls(input int slot);
        ls_done = 1'b1; ls_done_slot = 2'(slot);
    endtask

    task automatic expect_issue(input string tag, input bit ls, input int slot);
        check({tag, "_valid"}, 64'(ls ? ls_valid : alu_valid), 64'd1);
        check({tag, "_slot"},  64'(fu_slot), 64'(slot));
    endtask

    task automatic expect_idle(input string tag, input bit ls);
        check(tag, 64'(ls ? ls_valid : alu_valid), 64'd0);
    endtask

    // Called right after the cycle carrying the done that unblocks a held instruction.
    task automatic after_release(input string tag, input bit ls, input int slot);
`ifdef ISSUE_BYPASS_EN
        expect_issue(tag, ls, slot);
`else
        expect_idle({tag, "_extra_stall"}, ls);
        cycle();
        expect_issue(tag, ls, slot);
`endif
        cycle();
        expect_idle({tag, "_one_cycle"}, ls);
    endtask

    // Send an instruction and expect it to issue with no stall (valid after edge N+1).
    task automatic issue_now(input string tag, input logic [6:0] opt, input int rs1, input int rs2,
                             input int rd, input bit ls, input int slot);
        send(opt, rs1, rs2, rd);
        cycle();
        cycle();
        expect_issue(tag, ls, slot);
    endtask

    logic [6:0] ops [6];

    initial begin
        ops = '{OPC_R, OPC_I, OPC_B, OPC_L, OPC_S, OPC_BAD};
        model_reset();

        // Reset values
        rst_n = 1'b0;
        cycles(2);
        check("rst_vacant_alu", 64'(ib_vacant_alu), 64'd1);
        check("rst_vacant_ls",  64'(ib_vacant_ls),  64'd1);
        check("rst_alu_valid",  64'(alu_valid),     64'd0);
        check("rst_fu_imm",     64'(fu_imm),        64'd0);
        rst_n = 1'b1;
        cycle();

        // R-type rd=5 rs1=1 rs2=2: HOLD after N, issue after N+1 to slot 0
        send(OPC_R, 1, 2, 5);
        cycle();
        check("hold_vacant_alu", 64'(ib_vacant_alu), 64'd0);
        check("hold_vacant_ls",  64'(ib_vacant_ls),  64'd0);
        expect_idle("hold_no_issue", 0);
        cycle();
        expect_issue("r_issue", 0, 0);
        check("r_issue_rd", 64'(fu_rd), 64'd5);
        cycle();
        expect_idle("r_issue_one_cycle", 0);

        // pending[5] is set: an I-type writing rd=5 waits until slot 0 completes
        send(OPC_I, 0, 0, 5);
        cycles(3);
        expect_idle("waw5_stall", 0);
        done_alu(0);
        cycle();
        after_release("waw5_release", 0, 0);

        // RAW: L reading rs1=5 stalls until the I-type completes
        send(OPC_L, 5, 0, 6);
        cycle();
        check("raw_vacant_alu", 64'(ib_vacant_alu), 64'd0);
        check("raw_vacant_ls",  64'(ib_vacant_ls),  64'd0);
        cycles(2);
        expect_idle("raw_stall", 1);
        done_alu(0);
        cycle();
        after_release("raw_release", 1, 0);

        // Slot exhaustion: two ALU issues fill both ALU slots
        issue_now("fill_a", OPC_I, 1, 0, 8, 0, 0);
        issue_now("fill_b", OPC_R, 2, 3, 9, 0, 1);
        check("full_vacant_alu", 64'(ib_vacant_alu), 64'd0);
        check("full_vacant_ls",  64'(ib_vacant_ls),  64'd1);
        done_alu(1);
        cycle();
        check("freed_vacant_alu", 64'(ib_vacant_alu), 64'd1);
        issue_now("refill_slot1", OPC_B, 1, 2, 0, 0, 1);

        // Simultaneous ALU and LS completion: both slots and both registers freed
        done_alu(0);
        done_ls(0);
        cycle();
        check("dual_done_vacant_ls", 64'(ib_vacant_ls), 64'd1);
        issue_now("dual_done_regs", OPC_L, 8, 0, 6, 1, 0);
        done_alu(1);
        done_ls(0);
        cycle();

        // S-type stalls on rs2; rd=0 and rs1=0 never stall
        issue_now("wr7", OPC_I, 0, 0, 7, 0, 0);
        send(OPC_S, 0, 7, 0);
        cycles(3);
        expect_idle("s_rs2_stall", 1);
        done_alu(0);
        cycle();
        after_release("s_rs2_release", 1, 0);
        issue_now("x0_rd", OPC_I, 3, 0, 0, 0, 0);
        issue_now("x0_src", OPC_R, 0, 0, 4, 0, 1);
        done_alu(0);
        done_ls(0);
        cycle();
        done_alu(1);
        cycle();

        // Same-edge issue and done on rd=3: the new writer keeps pending[3]
        issue_now("wr3", OPC_I, 0, 0, 3, 0, 0);
        send(OPC_I, 1, 0, 3);
        cycles(2);
        expect_idle("waw3_stall", 0);
        done_alu(0);
        cycle();
        after_release("waw3_release", 0, 0);
        send(OPC_L, 3, 0, 12);
        cycles(3);
        expect_idle("pend3_kept", 1);
        done_alu(0);
        cycle();
        after_release("pend3_release", 1, 0);

        // Reset while holding with both ALU slots busy
        issue_now("busy_a", OPC_I, 0, 0, 13, 0, 0);
        issue_now("busy_b", OPC_I, 0, 0, 14, 0, 1);
        send(OPC_I, 0, 0, 15);
        cycles(2);
        expect_idle("no_slot_stall", 0);
        check("no_slot_vacant_ls", 64'(ib_vacant_ls), 64'd0);
        rst_n = 1'b0;
        cycle();
        check("midrst_vacant_alu", 64'(ib_vacant_alu), 64'd1);
        check("midrst_vacant_ls",  64'(ib_vacant_ls),  64'd1);
        rst_n = 1'b1;
        done_ls(1);
        cycle();
        check("stale_done_vacant_ls", 64'(ib_vacant_ls), 64'd1);
        issue_now("post_rst_pend_clear", OPC_R, 13, 14, 12, 0, 0);
        issue_now("post_rst_ls_free", OPC_L, 15, 0, 16, 1, 0);

        // Unknown opcode is discarded without issue
        send(OPC_BAD, 1, 2, 3);
        cycles(2);
        check("bad_op_no_issue", 64'(alu_valid | ls_valid), 64'd0);
        check("bad_op_vacant_alu", 64'(ib_vacant_alu), 64'd1);

        // Randomized traffic: small register range to provoke hazards, random completions
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            if (!m_hold && $urandom_range(0, 2) == 0)
                send(ops[$urandom_range(0, 5)], int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) done_alu(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) done_ls(int'($urandom_range(0, 3)));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Issue controller between the instruction buffer and the functional-unit slots. It accepts one decoded instruction at a time through the buffer's valid/vacant handshake and holds it until two conditions are met: no pending-write hazard on its registers, and a free slot in the matching unit class (ALU or LS). It then issues the instruction to the lowest-index free slot. It tracks per-slot occupancy and per-register pending writes, and frees both on unit completion.

## Interface
Parameters:
- `ALU_SLOTS`, default 2: number of ALU reservation slots; range 1..4.
- `LS_SLOTS`, default 2: number of LS reservation slots; range 1..4.

Ports:
- `clk` in 1: clock; all logic is rising-edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `ib_vacant_alu` out 1: holding register empty and at least one ALU slot free.
- `ib_vacant_ls` out 1: holding register empty and at least one LS slot free.
- `ib_valid` in 1: one-cycle instruction pulse from the buffer.
- `ib_opt` in `OPT_WID`, `ib_funct` in `FUNCT3_WID`, `ib_rs1`/`ib_rs2`/`ib_rd` in `REG_WID`, `ib_imm` in `XLEN`: instruction fields.
- `alu_valid` out 1: one-cycle issue pulse to the ALU class.
- `ls_valid` out 1: one-cycle issue pulse to the LS class.
- `fu_slot` out 2: destination slot index for the current issue.
- `fu_opt`, `fu_funct`, `fu_rs1`, `fu_rs2`, `fu_rd`, `fu_imm` out: issued fields; same widths as the `ib_*` fields; registered.
- `alu_done` in 1, `alu_done_slot` in 2: ALU slot completion pulse.
- `ls_done` in 1, `ls_done_slot` in 2: LS slot completion pulse.

## Operation
- Opcode classes:
  - ALU: B `1100011`, I `0010011`, R `0110011`.
  - LS: L `0000011`, S `0100011`.
- Register usage:
  - rs1 is read by all five classes.
  - rs2 is read by R, S, B only.
  - rd is written by R, I, L only.
  - Register x0 never causes a hazard and is never marked pending.
- State machine:
  - EMPTY: on `ib_valid`, capture all fields into the hold register and go to HOLD.
  - HOLD: issue when every used source and the rd are not pending and the class has a free slot. On issue, drive `alu_valid` or `ls_valid` high for 1 cycle, mark the slot busy, record rd in the slot, set `pending[rd]`, and return to EMPTY.
  - HOLD with an opcode outside the five classes: discard it and return to EMPTY; no issue occurs.
- Slot choice: the lowest-index free slot in the class.
- Completion: a done pulse frees the named slot and clears `pending` for that slot's recorded rd. A done for a slot that is already free is ignored.
- Simultaneous alu_done and ls_done: both are processed.
- Issue and done in the same cycle on the same rd: the set wins, because the newer writer owns the register.
- `ib_valid` while not in EMPTY: not permitted; the bench asserts on it.

## Timing
- Reset values:
  - `ib_vacant_alu` = 1, `ib_vacant_ls` = 1.
  - `alu_valid` = 0, `ls_valid` = 0, `fu_slot` = 0, all `fu_*` fields = 0.
  - All slots free; `pending` = 0; state EMPTY.
- Reset mid-operation: the held instruction and all occupancy are dropped. A done that arrives after reset hits a free slot and is ignored.
- Latency:
  - `ib_valid` sampled at edge N gives state HOLD and both vacant signals = 0 after edge N.
  - With no hazard, issue valid is high after edge N+1, for exactly one cycle.
- Vacant outputs are registered: they reflect state, slots and pending after each edge. They return high the cycle after issue if a slot remains free.
- A done sampled at edge M takes effect on the slot/pending state after edge M. Without bypass, an instruction stalled on that slot or register issues at edge M+1.

## Configuration
- `ISSUE_BYPASS_EN` defined:
  - The issue decision at edge M uses slot/pending state with that edge's done already applied.
  - A stalled instruction issues at edge M, with valid high after edge M.
  - A freed slot may be reissued in the same cycle it is freed.
- `ISSUE_BYPASS_EN` undefined:
  - The issue decision uses registered state only, so one extra cycle of stall is added.

## Test plan
- Reset, then an R-type with rd=5, rs1=1, rs2=2 -> `alu_valid` pulses 1 cycle after HOLD, with `fu_slot`=0 and `pending[5]`=1.
- RAW: I-type with rd=5, then an L-type with rs1=5 -> the L stays in HOLD and `ib_vacant_*`=0. After `alu_done` on slot 0, `ls_valid` fires 1 cycle later, or in the same edge with `ISSUE_BYPASS_EN`.
- Slot exhaustion with `ALU_SLOTS`=2: two ALU issues -> `ib_vacant_alu`=0 while `ib_vacant_ls`=1. `alu_done_slot`=1 -> next ALU issue uses slot 1.
- x0 and S-type: S with rs2=7 pending stalls. I-type with rd=0 sets no pending bit, and a following rs1=0 instruction issues without stall.
- Same-cycle issue of rd=3 with a done clearing rd=3 -> `pending[3]`=1 afterwards. Simultaneous `alu_done` and `ls_done` both free their slots.
- Deassert `rst_n` while in HOLD with two slots busy -> next cycle both vacant=1 and `pending`=0. A stale `ls_done` on slot 1 is ignored.
